// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Purpose  : Multi-channel pushbutton/switch conditioner. Each channel is
//            optionally inverted, passed through a two-flop synchroniser and
//            filtered by its own stability counter. Each channel produces a
//            clean level, one-cycle press/release pulses and an optional
//            hold-to-repeat pulse train.
// Ports    : clk        - system clock
//            rst        - asynchronous, active-low reset
//            btn_in     - raw asynchronous inputs, one bit per channel
//            btn_level  - debounced level (1 = pressed, after INVERT)
//            btn_rise   - one-cycle pulse when btn_level goes 0->1
//            btn_fall   - one-cycle pulse when btn_level goes 1->0
//            btn_rpt    - one-cycle auto-repeat pulses while held
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int              N_CH          = 4,
    parameter int              DB_CYCLES     = 524288,
    parameter int              HOLD_CYCLES   = 25000000,
    parameter int              REPEAT_CYCLES = 5000000,
    parameter int              REPEAT_EN     = 1,
    parameter logic [N_CH-1:0] INVERT        = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_rpt
);

    // ------------------------------------------------------------------------
    // Counter widths. The hold counter is shared by the first-repeat and the
    // repeat-period phases, so it is sized for the larger of the two.
    // Widths are clamped to one bit so degenerate settings still elaborate.
    // ------------------------------------------------------------------------
    localparam int c_DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_HOLD_W   = (c_HOLD_MAX > 1) ? $clog2(c_HOLD_MAX) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_REP_LAST  = c_HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch

            logic              r_s1;
            logic              r_s2;
            logic              r_level;
            logic              r_rise;
            logic              r_fall;
            logic [c_DB_W-1:0] r_db_cnt;

            logic w_differ;
            logic w_db_done;
            logic w_rise_evt;
            logic w_fall_evt;

            // The synchronised sample disagrees with the current level, and
            // has done so for DB_CYCLES consecutive edges when the counter
            // sits at its terminal value.
            assign w_differ   = (r_s2 != r_level);
            assign w_db_done  = w_differ && (r_db_cnt == c_DB_LAST);
            assign w_rise_evt = w_db_done &&  r_s2;
            assign w_fall_evt = w_db_done && !r_s2;

            // ----------------------------------------------------------------
            // Synchroniser and debounce filter. Polarity is fixed before the
            // first flop so everything downstream sees "pressed = 1".
            // ----------------------------------------------------------------
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_level  <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_s1   <= btn_in[gi] ^ INVERT[gi];
                    r_s2   <= r_s1;
                    r_rise <= w_rise_evt;
                    r_fall <= w_fall_evt;
                    if (!w_differ) begin
                        // Any return to the current level restarts the
                        // window, which is what discards short glitches.
                        r_db_cnt <= '0;
                    end else if (w_db_done) begin
                        r_level  <= r_s2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_DB_ONE;
                    end
                end
            end

            assign btn_level[gi] = r_level;
            assign btn_rise[gi]  = r_rise;
            assign btn_fall[gi]  = r_fall;

            // ----------------------------------------------------------------
            // Hold-to-repeat state machine. It is driven by the same-edge
            // debounce events rather than the registered pulses, so WAIT is
            // entered on the edge that raises btn_level and the first repeat
            // lands exactly HOLD_CYCLES cycles after the btn_rise cycle.
            // ----------------------------------------------------------------
            if (REPEAT_EN != 0) begin : g_rpt

                typedef enum logic [1:0] {
                    ST_IDLE   = 2'd0,
                    ST_WAIT   = 2'd1,
                    ST_REPEAT = 2'd2
                } state_t;

                state_t                r_state;
                state_t                w_state_nxt;
                logic [c_HOLD_W-1:0]   r_hold_cnt;
                logic [c_HOLD_W-1:0]   w_hold_cnt_nxt;
                logic                  r_rpt;
                logic                  w_rpt_nxt;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= '0;
                        r_rpt      <= 1'b0;
                    end else begin
                        r_state    <= w_state_nxt;
                        r_hold_cnt <= w_hold_cnt_nxt;
                        r_rpt      <= w_rpt_nxt;
                    end
                end

                always_comb begin
                    w_state_nxt    = r_state;
                    w_hold_cnt_nxt = r_hold_cnt;
                    w_rpt_nxt      = 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            w_hold_cnt_nxt = '0;
                            if (w_rise_evt) begin
                                w_state_nxt = ST_WAIT;
                            end
                        end
                        ST_WAIT: begin
                            // Release wins over an expiring count: no repeat
                            // pulse may accompany the fall edge.
                            if (w_fall_evt) begin
                                w_state_nxt    = ST_IDLE;
                                w_hold_cnt_nxt = '0;
                            end else if (r_hold_cnt == c_HOLD_LAST) begin
                                w_state_nxt    = ST_REPEAT;
                                w_hold_cnt_nxt = '0;
                                w_rpt_nxt      = 1'b1;
                            end else begin
                                w_hold_cnt_nxt = r_hold_cnt + c_HOLD_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (w_fall_evt) begin
                                w_state_nxt    = ST_IDLE;
                                w_hold_cnt_nxt = '0;
                            end else if (r_hold_cnt == c_REP_LAST) begin
                                w_hold_cnt_nxt = '0;
                                w_rpt_nxt      = 1'b1;
                            end else begin
                                w_hold_cnt_nxt = r_hold_cnt + c_HOLD_ONE;
                            end
                        end
                        default: begin
                            w_state_nxt    = ST_IDLE;
                            w_hold_cnt_nxt = '0;
                        end
                    endcase
                end

                assign btn_rpt[gi] = r_rpt;

            end else begin : g_no_rpt
                assign btn_rpt[gi] = 1'b0;
            end

        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_bank
// Purpose  : Self-checking bench for debounce_bank. Directed scenarios are
//            followed by a long randomized phase, all compared cycle by cycle
//            against a window-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    localparam int         N_CH = 4;
    localparam int         DB   = 8;
    localparam int         HOLD = 20;
    localparam int         REP  = 5;
    localparam logic [3:0] INV  = 4'b1000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_rpt;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH          (N_CH),
        .DB_CYCLES     (DB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .REPEAT_EN     (1),
        .INVERT        (INV)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_rpt   (btn_rpt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per channel, the history of polarity-corrected input
    // samples (index 0 = sampled at the latest edge). The level flips when the
    // DB samples that have reached the end of the synchroniser all disagree
    // with it. Repeats are derived from the distance to the press edge.
    logic [DB+1:0]   hist [N_CH];
    logic [N_CH-1:0] m_level;
    logic [N_CH-1:0] m_rise;
    logic [N_CH-1:0] m_fall;
    logic [N_CH-1:0] m_rpt;
    int              rise_edge [N_CH];
    int              edge_no = 0;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < N_CH; ch++) begin
            hist[ch]      = '0;
            rise_edge[ch] = -1;
        end
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_rpt   = '0;
    endtask

    task automatic model_edge();
        logic flip;
        int   d;
        edge_no++;
        if (!rst) begin
            model_clear();
            return;
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            hist[ch]   = {hist[ch][DB:0], btn_in[ch] ^ INV[ch]};
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            m_rpt[ch]  = 1'b0;
            flip = 1'b1;
            for (int k = 2; k <= DB + 1; k++) begin
                if (hist[ch][k] == m_level[ch]) flip = 1'b0;
            end
            if (flip) begin
                m_level[ch] = ~m_level[ch];
                if (m_level[ch]) begin
                    m_rise[ch]    = 1'b1;
                    rise_edge[ch] = edge_no;
                end else begin
                    m_fall[ch]    = 1'b1;
                    rise_edge[ch] = -1;
                end
            end else if (rise_edge[ch] >= 0) begin
                d = edge_no - rise_edge[ch];
                m_rpt[ch] = (d == HOLD) || (d > HOLD && ((d - HOLD) % REP) == 0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_level"}, btn_level, m_level);
        check_eq({tag, "_rise"},  btn_rise,  m_rise);
        check_eq({tag, "_fall"},  btn_fall,  m_fall);
        check_eq({tag, "_rpt"},   btn_rpt,   m_rpt);
    endtask

    // One clock: advance the model on the edge, compare just after it.
    // Inputs are only ever changed by the caller after this returns.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        model_clear();
        check_all("rst_async");
    endtask

    int run_left [N_CH];

    initial begin
        rst    = 1'b0;
        btn_in = 4'b1000;   // inverted ch3 idles high
        model_clear();

        repeat (3) cycle("reset");
        rst = 1'b1;
        repeat (12) cycle("idle");

        // ch0 and ch1 pressed together, ch3 pressed by driving it low.
        btn_in = 4'b0011;
        repeat (30) cycle("press01");
        btn_in = 4'b1000;
        repeat (30) cycle("release01");

        // Long hold on ch2 to run through several repeat periods.
        btn_in = 4'b1100;
        repeat (85) cycle("hold2");

        // Press ch0 and abort mid-count (db_cnt = 5) while ch2 repeats.
        btn_in = 4'b1101;
        repeat (7) cycle("pre_rst");
        assert_reset();
        repeat (3) cycle("in_rst");
        rst = 1'b1;
        repeat (40) cycle("post_rst");
        btn_in = 4'b1000;
        repeat (30) cycle("release_all");

        // Randomized phase: short glitch runs around the filter length mixed
        // with long holds, plus occasional asynchronous resets.
        for (int ch = 0; ch < N_CH; ch++) run_left[ch] = 0;
        for (int n = 0; n < 5000; n++) begin
            cycle("rand");
            for (int ch = 0; ch < N_CH; ch++) begin
                if (run_left[ch] == 0) begin
                    btn_in[ch]   = 1'($urandom_range(0, 1));
                    run_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                               : int'($urandom_range(1, 9));
                end else begin
                    run_left[ch]--;
                end
            end
            if (!rst) begin
                if ($urandom_range(0, 2) == 0) rst = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                assert_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel debouncer with edge and auto-repeat detection. It takes N_CH raw pushbutton or switch inputs and synchronises each one. It filters each channel with an independent stability counter and produces a clean level, single-cycle press/release pulses and an optional hold-to-repeat pulse train. It sits between the board pins and the control logic, for example VGA demo mode selection and cursor movement, and replaces per-button debouncer instances with a single bank.

## Interface

Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- N_CH, 4: number of independent channels.
- DB_CYCLES, 524288: consecutive cycles a synchronised input must differ from the current level before the level changes. Must be ≥ 2.
- HOLD_CYCLES, 25000000: cycles from press to the first repeat pulse. Must be ≥ 1.
- REPEAT_CYCLES, 5000000: cycles between subsequent repeat pulses. Must be ≥ 1.
- REPEAT_EN, 1: 1 enables the repeat logic; 0 ties btn_rpt to 0 and removes the hold counters.
- INVERT, {N_CH{1'b0}}: per-channel polarity mask. A set bit inverts that raw input before synchronisation, so active-low buttons read "pressed = 1".

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- btn_in  input  N_CH  raw asynchronous inputs.
- btn_level  output  N_CH  debounced level, 1 = pressed after INVERT.
- btn_rise  output  N_CH  one-cycle pulse when btn_level goes 0→1.
- btn_fall  output  N_CH  one-cycle pulse when btn_level goes 1→0.
- btn_rpt  output  N_CH  one-cycle auto-repeat pulses while the channel is held.

## Operation

Each channel is fully independent; there is no shared state between channels.
- Synchronisation:
  - s1 <= btn_in[i] ^ INVERT[i].
  - s2 <= s1.
  - raw = s2.
- Debounce counter db_cnt, width $clog2(DB_CYCLES):
  - If raw == btn_level: db_cnt <= 0.
  - Else if db_cnt == DB_CYCLES-1: btn_level <= raw and db_cnt <= 0. In the same edge, btn_rise <= raw and btn_fall <= ~raw.
  - Else: db_cnt <= db_cnt+1.
- Any glitch shorter than DB_CYCLES cycles is discarded, because db_cnt restarts from 0 on every return to the current level.
- btn_rise and btn_fall are registered. Each is high for exactly one cycle and low otherwise.
- Repeat FSM per channel, active only when REPEAT_EN=1; hold counter width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)):
  - IDLE: btn_level==0; hold_cnt=0. On the rise edge, go to WAIT with hold_cnt <= 0.
  - WAIT: each cycle hold_cnt++. At hold_cnt==HOLD_CYCLES-1: btn_rpt pulse, hold_cnt <= 0, go to REPEAT.
  - REPEAT: each cycle hold_cnt++. At hold_cnt==REPEAT_CYCLES-1: btn_rpt pulse, hold_cnt <= 0, stay in REPEAT.
  - From WAIT or REPEAT, on the fall edge go to IDLE and clear hold_cnt. No btn_rpt is emitted in the fall cycle, even if the count would expire on that edge.
- btn_rpt never coincides with btn_rise.
- Reset (rst=0, asynchronous) forces all state to 0: s1, s2, db_cnt, btn_level, btn_rise, btn_fall, btn_rpt, hold_cnt, FSM=IDLE.
  - No pulse is generated on reset entry or exit.
  - Reset asserted mid-count or mid-repeat aborts the operation immediately.
  - If a channel is still pressed when reset releases, it produces a normal btn_rise after the full latency.

## Timing

- Reset values: all outputs 0.
- Press latency: btn_in changes before clock edge E0 and stays stable.
  - E0: s1 updates.
  - E1: s2 updates.
  - E2 … E(DB_CYCLES+1): db_cnt counts 0 → DB_CYCLES-1.
  - btn_level and btn_rise go high after edge E(DB_CYCLES+1).
  - Total latency is DB_CYCLES+2 clock edges; the same applies to release and btn_fall.
- First btn_rpt occurs HOLD_CYCLES cycles after the btn_rise cycle. Each later pulse follows REPEAT_CYCLES cycles after the previous one.
- Multiple channels may assert any outputs in the same cycle.
- Inputs may change at any time relative to clk; the 2-FF synchroniser is the only metastability protection.

## Test plan

Sim parameters for all scenarios: N_CH=4, DB_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, INVERT=4'b1000.
- Clean press on ch0: btn_in[0] 0→1 before E0 → btn_level[0]=1 and btn_rise[0]=1 for one cycle after E9. Release → btn_fall[0] after 10 edges.
- Bounce on ch1: pulses of 1–7 cycles separated by 1–3 low cycles for 60 cycles, then held high → no output changes during the bounce. btn_rise[1] comes exactly 10 edges after the last 0→1 transition.
- Hold on ch2 for 60 cycles after btn_rise → btn_rpt[2] at +20, +25, +30 … +60 cycles. Release → no further btn_rpt, and btn_fall[2] fires.
- Inverted ch3:
  - btn_in[3]=1 at reset → btn_level[3]=0 and no events.
  - Drive btn_in[3]=0 → btn_rise[3] after 10 edges.
- Reset mid-operation:
  - Assert rst=0 while ch0 db_cnt=5 and ch2 is in REPEAT → all outputs 0 immediately.
  - Release rst with ch0 still high → btn_rise[0] exactly 10 edges later, with no repeat carried over.
- Simultaneous events: press ch0 and ch1 on the same edge → both btn_rise pulses occur in the same cycle.
